xor_cipher_scheduler: RTL and testbench

//  - Shares one bitwise-XOR cipher unit between NUM_REQ word-stream requesters (e.g. ch0 encrypt, ch1 decrypt).
//  - Holds the loaded key. Keeps one rolling key per requester, rotated after each word that requester gets through.
//  - Round-robin arbitration; valid/ready on every port; 1-entry registered output.
//  - Sits between the word sources and the downstream sink, and sequences the XOR datapath.

---
 rtl/cipher_pkg.sv | 22 ++
 rtl/xor_word_unit.sv | 13 +
 rtl/xor_cipher_scheduler.sv | 132 +++++++++++++
 tb/tb_xor_cipher_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types and helpers for the XOR cipher scheduler.
// Holds the default word width, FSM state type and key rotation helper.
package cipher_pkg;

    localparam int CIPHER_WIDTH   = 4;
    localparam int CIPHER_NUM_REQ = 2;
    localparam int CIPHER_ID_W    = $clog2(CIPHER_NUM_REQ);

    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef logic [CIPHER_ID_W-1:0] req_id_t;

    function automatic logic [CIPHER_WIDTH-1:0] rotl1(
        input logic [CIPHER_WIDTH-1:0] key
    );
        return {key[CIPHER_WIDTH-2:0], key[CIPHER_WIDTH-1]};
    endfunction

endpackage

// File: rtl/xor_word_unit.sv
// Shared combinational XOR datapath: o1 = i1 ^ i2.
// Ports: i1 (word), i2 (rolling key), o1 (ciphered word), all WIDTH bits.
module xor_word_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] o1
);

    assign o1 = i1 ^ i2;

endmodule

// File: rtl/xor_cipher_scheduler.sv
// Round-robin scheduler sharing one XOR cipher unit between NUM_REQ streams.
// Ports: clk/rst (sync, active-high), key_load/key_in/key_ready key port,
// req_valid/req_word/req_ready requesters, out_valid/out_word/out_id/
// out_ready registered output slot, busy status.
module xor_cipher_scheduler
    import cipher_pkg::*;
#(
    parameter int WIDTH   = CIPHER_WIDTH,
    parameter int NUM_REQ = 2,
    parameter int ROTATE  = 1,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_load,
    input  logic [WIDTH-1:0]         key_in,
    output logic                     key_ready,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_word,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_word,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready,
    output logic                     busy
);

    state_t           state_q;
    logic [ID_W-1:0]  rr_q;
    logic [WIDTH-1:0] rkey_q [NUM_REQ];

    logic             slot_free;
    logic             key_fire;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  rr_next;
    logic             accept;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] sel_key;
    logic [WIDTH-1:0] xor_out;

    assign slot_free = !out_valid || out_ready;
    assign key_ready = slot_free;
    assign key_fire  = key_load && key_ready;

    // A key load in the same cycle blocks word acceptance.
    assign accept = (state_q == RUN) && slot_free && !key_fire && gnt_found;

    assign busy = out_valid || ((state_q == RUN) && (|req_valid));

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[ID_W-1:0];
            end
        end
    end

    assign rr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    // Route the granted word and its rolling key into the shared unit.
    always_comb begin
        sel_word = '0;
        sel_key  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_word = req_word[i*WIDTH +: WIDTH];
                sel_key  = rkey_q[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (gnt_id == ID_W'(i));
        end
    end

    xor_word_unit #(
        .WIDTH (WIDTH)
    ) u_xor (
        .i1 (sel_word),
        .i2 (sel_key),
        .o1 (xor_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NOKEY;
            rr_q      <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_id    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rkey_q[i] <= '0;
            end
        end else begin
            if (key_fire) begin
                state_q <= RUN;
                for (int i = 0; i < NUM_REQ; i++) begin
                    rkey_q[i] <= key_in;
                end
            end else if (accept) begin
                rr_q <= rr_next;
                if (ROTATE != 0) begin
                    rkey_q[gnt_id] <= {sel_key[WIDTH-2:0], sel_key[WIDTH-1]};
                end
            end

            // Accept wins over drain so back-to-back words keep flowing.
            if (accept) begin
                out_valid <= 1'b1;
                out_word  <= xor_out;
                out_id    <= gnt_id;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_cipher_scheduler.sv
// Self-checking bench for xor_cipher_scheduler (WIDTH=4, NUM_REQ=2).
// Scenario tasks plus a scoreboard checked on every output handshake.
module tb_xor_cipher_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_load;
    logic [3:0] key_in;
    logic       key_ready;
    logic [1:0] req_valid;
    logic [7:0] req_word;
    logic [1:0] req_ready;
    logic       out_valid;
    logic [3:0] out_word;
    logic       out_id;
    logic       out_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [4:0] sb [$];

    bit         m_run;
    int         m_rr;
    logic [3:0] m_key [2];
    bit         m_ov;

    logic [1:0] obs_rdy;
    logic       obs_kr;

    xor_cipher_scheduler #(
        .WIDTH   (4),
        .NUM_REQ (2),
        .ROTATE  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .req_valid (req_valid),
        .req_word  (req_word),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got word=%b id=%0d, required no output", out_word, out_id);
            end else begin
                e = sb.pop_front();
                if ({out_id, out_word} !== e) begin
                    errors++;
                    $display("FAIL sb_data: got word=%b id=%0d, required word=%b id=%0d",
                             out_word, out_id, e[3:0], e[4]);
                end
            end
        end
    end

    // One clock: sample handshakes, advance the reference model, step edge.
    task automatic cycle();
        bit         slot;
        bit         kl;
        int         g;
        int         idx;
        logic [3:0] w;
        @(negedge clk);
        obs_rdy = req_ready;
        obs_kr  = key_ready;
        if (rst) begin
            m_run = 0;
            m_rr  = 0;
            m_key[0] = 4'b0;
            m_key[1] = 4'b0;
            m_ov  = 0;
            sb.delete();
        end else begin
            slot = !m_ov || out_ready;
            kl   = key_load && slot;
            g    = -1;
            if (m_run && !kl && slot) begin
                for (int k = 0; k < 2; k++) begin
                    idx = (m_rr + k) % 2;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (kl) begin
                m_run = 1;
                m_key[0] = key_in;
                m_key[1] = key_in;
            end
            if (g >= 0) begin
                w = (g == 0) ? req_word[3:0] : req_word[7:4];
                sb.push_back({g[0], w ^ m_key[g]});
                m_key[g] = {m_key[g][2:0], m_key[g][3]};
                m_rr = (g + 1) % 2;
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; key_load = 0; key_in = 4'b0;
        req_valid = 2'b01; req_word = 8'h00; out_ready = 1;
        cycle();
        cycle();
        rst = 0;
        cycle();
        checks++;
        if (obs_rdy !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready: got %b, required 00", obs_rdy);
        end
        checks++;
        if (obs_kr !== 1'b1) begin
            errors++; $display("FAIL reset_key_ready: got %b, required 1", obs_kr);
        end
        checks++;
        if ({out_valid, out_word, out_id, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b w=%b id=%b busy=%b, required all 0",
                     out_valid, out_word, out_id, busy);
        end
        cycle();
        checks++;
        if (obs_rdy !== 2'b00 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_nokey: got rdy=%b v=%b, required 00/0", obs_rdy, out_valid);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_two_words();
        key_load = 1; key_in = 4'b1001;
        cycle();
        checks++;
        if (obs_kr !== 1'b1) begin
            errors++; $display("FAIL t2_key_ready: got %b, required 1", obs_kr);
        end
        key_load = 0;
        req_valid = 2'b01; req_word = {4'b0000, 4'b0110};
        cycle();
        checks++;
        if (obs_rdy !== 2'b01 || out_valid !== 1'b1 || out_word !== 4'b1111 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL t2_word0: got rdy=%b v=%b w=%b id=%0d, required 01 1 1111 0",
                     obs_rdy, out_valid, out_word, out_id);
        end
        cycle();
        checks++;
        if (obs_rdy !== 2'b01 || out_word !== 4'b0101 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL t2_word1: got rdy=%b w=%b id=%0d, required 01 0101 0",
                     obs_rdy, out_word, out_id);
        end
        req_valid = 2'b00;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t2_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_enc_dec();
        key_load = 1; key_in = 4'b1001;
        cycle();
        key_load = 0;
        req_valid = 2'b01; req_word = {4'b0000, 4'b0110};
        cycle();
        checks++;
        if (out_word !== 4'b1111 || out_id !== 1'b0) begin
            errors++; $display("FAIL t3_encrypt: got w=%b id=%0d, required 1111 0", out_word, out_id);
        end
        req_valid = 2'b10; req_word = {4'b1111, 4'b0000};
        cycle();
        checks++;
        if (obs_rdy !== 2'b10 || out_word !== 4'b0110 || out_id !== 1'b1) begin
            errors++;
            $display("FAIL t3_decrypt: got rdy=%b w=%b id=%0d, required 10 0110 1",
                     obs_rdy, out_word, out_id);
        end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        req_valid = 2'b11; req_word = {4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            cycle();
            checks++;
            if (obs_rdy !== want || out_id !== want[1]) begin
                errors++;
                $display("FAIL t4_grant%0d: got rdy=%b id=%0d, required %b id=%0d",
                         i, obs_rdy, out_id, want, want[1]);
            end
        end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_backpressure();
        key_load = 1; key_in = 4'b1001;
        cycle();
        key_load = 0;
        req_valid = 2'b01; req_word = {4'b0000, 4'b0110};
        cycle();
        out_ready = 0; key_load = 1; key_in = 4'b0101;
        req_word = 8'h00;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== 2'b00 || obs_kr !== 1'b0 || out_valid !== 1'b1 ||
                out_word !== 4'b1111 || busy !== 1'b1) begin
                errors++;
                $display("FAIL t5_stall%0d: got rdy=%b kr=%b v=%b w=%b busy=%b, required 00 0 1 1111 1",
                         i, obs_rdy, obs_kr, out_valid, out_word, busy);
            end
        end
        key_load = 0; out_ready = 1;
        cycle();
        checks++;
        if (obs_rdy !== 2'b01 || out_word !== 4'b0011) begin
            errors++;
            $display("FAIL t5_release: got rdy=%b w=%b, required 01 0011", obs_rdy, out_word);
        end
        req_valid = 2'b00;
        cycle();
    endtask

    task automatic test_simultaneous();
        key_load = 1; key_in = 4'b0011;
        req_valid = 2'b01; req_word = 8'h00;
        cycle();
        checks++;
        if (obs_rdy !== 2'b00 || obs_kr !== 1'b1) begin
            errors++; $display("FAIL t6_key_wins: got rdy=%b kr=%b, required 00 1", obs_rdy, obs_kr);
        end
        key_load = 0;
        cycle();
        checks++;
        if (obs_rdy !== 2'b01 || out_word !== 4'b0011) begin
            errors++; $display("FAIL t6_new_key: got rdy=%b w=%b, required 01 0011", obs_rdy, out_word);
        end
        out_ready = 0; req_word = {4'b0000, 4'b0101};
        cycle();
        rst = 1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL t6_rst_drop: got out_valid=%b, required 0", out_valid);
        end
        rst = 0; out_ready = 1;
        cycle();
        checks++;
        if (obs_rdy !== 2'b00 || out_valid !== 1'b0) begin
            errors++; $display("FAIL t6_rst_nokey: got rdy=%b v=%b, required 00 0", obs_rdy, out_valid);
        end
        req_valid = 2'b00;
        cycle();
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_enc_dec();
        test_round_robin();
        test_backpressure();
        test_simultaneous();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_missing: %0d outputs never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
